inv_sub_bytes_seq: RTL and testbench

Iterative inverse SubBytes engine for the AES-128 decryption datapath. Accepts one 128-bit state over a valid/ready handshake and applies the inverse S-box to all 16 bytes using `LANES` inverse S-box instances, `LANES` bytes per cycle. It holds the result until the downstream stage accepts it. It sits between InvShiftRows and AddRoundKey in the decryptor round loop, and is the decrypt-side counterpart of the combinational SubBytes stage.

---
 rtl/inv_sub_bytes_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sub_bytes_seq
//  Description : Iterative AES inverse SubBytes engine. Accepts one 128-bit
//                state over valid/ready, substitutes LANES bytes per cycle
//                (byte 0 = in[127:120] first), then holds the result until
//                the downstream stage takes it.
//                Optional macro INV_SUBBYTES_FWD_EN adds a 'fwd' port that
//                selects the forward S-box for the whole block, so one
//                engine can serve both encrypt and decrypt paths.
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out
`ifdef INV_SUBBYTES_FWD_EN
    ,
    input  logic         fwd
`endif
);

    localparam int c_NGRP = 16 / LANES;
    localparam int c_GW   = (c_NGRP > 1) ? $clog2(c_NGRP) : 1;
    localparam logic [c_GW-1:0] c_LAST = c_GW'(c_NGRP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [127:0]           r_data;
    logic [127:0]           w_data_sub;
    logic [c_GW-1:0]        r_grp;
    logic                   w_load;
    logic                   w_step;
    logic [LANES-1:0][7:0]  w_lane_in;
    logic [LANES-1:0][7:0]  w_lane_out;
`ifdef INV_SUBBYTES_FWD_EN
    logic                   r_fwd;
`endif

    // FIPS-197 inverse S-box
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        case (b)
            8'h00: inv_sbox = 8'h52; 8'h01: inv_sbox = 8'h09; 8'h02: inv_sbox = 8'h6a; 8'h03: inv_sbox = 8'hd5; 8'h04: inv_sbox = 8'h30; 8'h05: inv_sbox = 8'h36; 8'h06: inv_sbox = 8'ha5; 8'h07: inv_sbox = 8'h38;
            8'h08: inv_sbox = 8'hbf; 8'h09: inv_sbox = 8'h40; 8'h0a: inv_sbox = 8'ha3; 8'h0b: inv_sbox = 8'h9e; 8'h0c: inv_sbox = 8'h81; 8'h0d: inv_sbox = 8'hf3; 8'h0e: inv_sbox = 8'hd7; 8'h0f: inv_sbox = 8'hfb;
            8'h10: inv_sbox = 8'h7c; 8'h11: inv_sbox = 8'he3; 8'h12: inv_sbox = 8'h39; 8'h13: inv_sbox = 8'h82; 8'h14: inv_sbox = 8'h9b; 8'h15: inv_sbox = 8'h2f; 8'h16: inv_sbox = 8'hff; 8'h17: inv_sbox = 8'h87;
            8'h18: inv_sbox = 8'h34; 8'h19: inv_sbox = 8'h8e; 8'h1a: inv_sbox = 8'h43; 8'h1b: inv_sbox = 8'h44; 8'h1c: inv_sbox = 8'hc4; 8'h1d: inv_sbox = 8'hde; 8'h1e: inv_sbox = 8'he9; 8'h1f: inv_sbox = 8'hcb;
            8'h20: inv_sbox = 8'h54; 8'h21: inv_sbox = 8'h7b; 8'h22: inv_sbox = 8'h94; 8'h23: inv_sbox = 8'h32; 8'h24: inv_sbox = 8'ha6; 8'h25: inv_sbox = 8'hc2; 8'h26: inv_sbox = 8'h23; 8'h27: inv_sbox = 8'h3d;
            8'h28: inv_sbox = 8'hee; 8'h29: inv_sbox = 8'h4c; 8'h2a: inv_sbox = 8'h95; 8'h2b: inv_sbox = 8'h0b; 8'h2c: inv_sbox = 8'h42; 8'h2d: inv_sbox = 8'hfa; 8'h2e: inv_sbox = 8'hc3; 8'h2f: inv_sbox = 8'h4e;
            8'h30: inv_sbox = 8'h08; 8'h31: inv_sbox = 8'h2e; 8'h32: inv_sbox = 8'ha1; 8'h33: inv_sbox = 8'h66; 8'h34: inv_sbox = 8'h28; 8'h35: inv_sbox = 8'hd9; 8'h36: inv_sbox = 8'h24; 8'h37: inv_sbox = 8'hb2;
            8'h38: inv_sbox = 8'h76; 8'h39: inv_sbox = 8'h5b; 8'h3a: inv_sbox = 8'ha2; 8'h3b: inv_sbox = 8'h49; 8'h3c: inv_sbox = 8'h6d; 8'h3d: inv_sbox = 8'h8b; 8'h3e: inv_sbox = 8'hd1; 8'h3f: inv_sbox = 8'h25;
            8'h40: inv_sbox = 8'h72; 8'h41: inv_sbox = 8'hf8; 8'h42: inv_sbox = 8'hf6; 8'h43: inv_sbox = 8'h64; 8'h44: inv_sbox = 8'h86; 8'h45: inv_sbox = 8'h68; 8'h46: inv_sbox = 8'h98; 8'h47: inv_sbox = 8'h16;
            8'h48: inv_sbox = 8'hd4; 8'h49: inv_sbox = 8'ha4; 8'h4a: inv_sbox = 8'h5c; 8'h4b: inv_sbox = 8'hcc; 8'h4c: inv_sbox = 8'h5d; 8'h4d: inv_sbox = 8'h65; 8'h4e: inv_sbox = 8'hb6; 8'h4f: inv_sbox = 8'h92;
            8'h50: inv_sbox = 8'h6c; 8'h51: inv_sbox = 8'h70; 8'h52: inv_sbox = 8'h48; 8'h53: inv_sbox = 8'h50; 8'h54: inv_sbox = 8'hfd; 8'h55: inv_sbox = 8'hed; 8'h56: inv_sbox = 8'hb9; 8'h57: inv_sbox = 8'hda;
            8'h58: inv_sbox = 8'h5e; 8'h59: inv_sbox = 8'h15; 8'h5a: inv_sbox = 8'h46; 8'h5b: inv_sbox = 8'h57; 8'h5c: inv_sbox = 8'ha7; 8'h5d: inv_sbox = 8'h8d; 8'h5e: inv_sbox = 8'h9d; 8'h5f: inv_sbox = 8'h84;
            8'h60: inv_sbox = 8'h90; 8'h61: inv_sbox = 8'hd8; 8'h62: inv_sbox = 8'hab; 8'h63: inv_sbox = 8'h00; 8'h64: inv_sbox = 8'h8c; 8'h65: inv_sbox = 8'hbc; 8'h66: inv_sbox = 8'hd3; 8'h67: inv_sbox = 8'h0a;
            8'h68: inv_sbox = 8'hf7; 8'h69: inv_sbox = 8'he4; 8'h6a: inv_sbox = 8'h58; 8'h6b: inv_sbox = 8'h05; 8'h6c: inv_sbox = 8'hb8; 8'h6d: inv_sbox = 8'hb3; 8'h6e: inv_sbox = 8'h45; 8'h6f: inv_sbox = 8'h06;
            8'h70: inv_sbox = 8'hd0; 8'h71: inv_sbox = 8'h2c; 8'h72: inv_sbox = 8'h1e; 8'h73: inv_sbox = 8'h8f; 8'h74: inv_sbox = 8'hca; 8'h75: inv_sbox = 8'h3f; 8'h76: inv_sbox = 8'h0f; 8'h77: inv_sbox = 8'h02;
            8'h78: inv_sbox = 8'hc1; 8'h79: inv_sbox = 8'haf; 8'h7a: inv_sbox = 8'hbd; 8'h7b: inv_sbox = 8'h03; 8'h7c: inv_sbox = 8'h01; 8'h7d: inv_sbox = 8'h13; 8'h7e: inv_sbox = 8'h8a; 8'h7f: inv_sbox = 8'h6b;
            8'h80: inv_sbox = 8'h3a; 8'h81: inv_sbox = 8'h91; 8'h82: inv_sbox = 8'h11; 8'h83: inv_sbox = 8'h41; 8'h84: inv_sbox = 8'h4f; 8'h85: inv_sbox = 8'h67; 8'h86: inv_sbox = 8'hdc; 8'h87: inv_sbox = 8'hea;
            8'h88: inv_sbox = 8'h97; 8'h89: inv_sbox = 8'hf2; 8'h8a: inv_sbox = 8'hcf; 8'h8b: inv_sbox = 8'hce; 8'h8c: inv_sbox = 8'hf0; 8'h8d: inv_sbox = 8'hb4; 8'h8e: inv_sbox = 8'he6; 8'h8f: inv_sbox = 8'h73;
            8'h90: inv_sbox = 8'h96; 8'h91: inv_sbox = 8'hac; 8'h92: inv_sbox = 8'h74; 8'h93: inv_sbox = 8'h22; 8'h94: inv_sbox = 8'he7; 8'h95: inv_sbox = 8'had; 8'h96: inv_sbox = 8'h35; 8'h97: inv_sbox = 8'h85;
            8'h98: inv_sbox = 8'he2; 8'h99: inv_sbox = 8'hf9; 8'h9a: inv_sbox = 8'h37; 8'h9b: inv_sbox = 8'he8; 8'h9c: inv_sbox = 8'h1c; 8'h9d: inv_sbox = 8'h75; 8'h9e: inv_sbox = 8'hdf; 8'h9f: inv_sbox = 8'h6e;
            8'ha0: inv_sbox = 8'h47; 8'ha1: inv_sbox = 8'hf1; 8'ha2: inv_sbox = 8'h1a; 8'ha3: inv_sbox = 8'h71; 8'ha4: inv_sbox = 8'h1d; 8'ha5: inv_sbox = 8'h29; 8'ha6: inv_sbox = 8'hc5; 8'ha7: inv_sbox = 8'h89;
            8'ha8: inv_sbox = 8'h6f; 8'ha9: inv_sbox = 8'hb7; 8'haa: inv_sbox = 8'h62; 8'hab: inv_sbox = 8'h0e; 8'hac: inv_sbox = 8'haa; 8'had: inv_sbox = 8'h18; 8'hae: inv_sbox = 8'hbe; 8'haf: inv_sbox = 8'h1b;
            8'hb0: inv_sbox = 8'hfc; 8'hb1: inv_sbox = 8'h56; 8'hb2: inv_sbox = 8'h3e; 8'hb3: inv_sbox = 8'h4b; 8'hb4: inv_sbox = 8'hc6; 8'hb5: inv_sbox = 8'hd2; 8'hb6: inv_sbox = 8'h79; 8'hb7: inv_sbox = 8'h20;
            8'hb8: inv_sbox = 8'h9a; 8'hb9: inv_sbox = 8'hdb; 8'hba: inv_sbox = 8'hc0; 8'hbb: inv_sbox = 8'hfe; 8'hbc: inv_sbox = 8'h78; 8'hbd: inv_sbox = 8'hcd; 8'hbe: inv_sbox = 8'h5a; 8'hbf: inv_sbox = 8'hf4;
            8'hc0: inv_sbox = 8'h1f; 8'hc1: inv_sbox = 8'hdd; 8'hc2: inv_sbox = 8'ha8; 8'hc3: inv_sbox = 8'h33; 8'hc4: inv_sbox = 8'h88; 8'hc5: inv_sbox = 8'h07; 8'hc6: inv_sbox = 8'hc7; 8'hc7: inv_sbox = 8'h31;
            8'hc8: inv_sbox = 8'hb1; 8'hc9: inv_sbox = 8'h12; 8'hca: inv_sbox = 8'h10; 8'hcb: inv_sbox = 8'h59; 8'hcc: inv_sbox = 8'h27; 8'hcd: inv_sbox = 8'h80; 8'hce: inv_sbox = 8'hec; 8'hcf: inv_sbox = 8'h5f;
            8'hd0: inv_sbox = 8'h60; 8'hd1: inv_sbox = 8'h51; 8'hd2: inv_sbox = 8'h7f; 8'hd3: inv_sbox = 8'ha9; 8'hd4: inv_sbox = 8'h19; 8'hd5: inv_sbox = 8'hb5; 8'hd6: inv_sbox = 8'h4a; 8'hd7: inv_sbox = 8'h0d;
            8'hd8: inv_sbox = 8'h2d; 8'hd9: inv_sbox = 8'he5; 8'hda: inv_sbox = 8'h7a; 8'hdb: inv_sbox = 8'h9f; 8'hdc: inv_sbox = 8'h93; 8'hdd: inv_sbox = 8'hc9; 8'hde: inv_sbox = 8'h9c; 8'hdf: inv_sbox = 8'hef;
            8'he0: inv_sbox = 8'ha0; 8'he1: inv_sbox = 8'he0; 8'he2: inv_sbox = 8'h3b; 8'he3: inv_sbox = 8'h4d; 8'he4: inv_sbox = 8'hae; 8'he5: inv_sbox = 8'h2a; 8'he6: inv_sbox = 8'hf5; 8'he7: inv_sbox = 8'hb0;
            8'he8: inv_sbox = 8'hc8; 8'he9: inv_sbox = 8'heb; 8'hea: inv_sbox = 8'hbb; 8'heb: inv_sbox = 8'h3c; 8'hec: inv_sbox = 8'h83; 8'hed: inv_sbox = 8'h53; 8'hee: inv_sbox = 8'h99; 8'hef: inv_sbox = 8'h61;
            8'hf0: inv_sbox = 8'h17; 8'hf1: inv_sbox = 8'h2b; 8'hf2: inv_sbox = 8'h04; 8'hf3: inv_sbox = 8'h7e; 8'hf4: inv_sbox = 8'hba; 8'hf5: inv_sbox = 8'h77; 8'hf6: inv_sbox = 8'hd6; 8'hf7: inv_sbox = 8'h26;
            8'hf8: inv_sbox = 8'he1; 8'hf9: inv_sbox = 8'h69; 8'hfa: inv_sbox = 8'h14; 8'hfb: inv_sbox = 8'h63; 8'hfc: inv_sbox = 8'h55; 8'hfd: inv_sbox = 8'h21; 8'hfe: inv_sbox = 8'h0c; 8'hff: inv_sbox = 8'h7d;
        endcase
    endfunction

`ifdef INV_SUBBYTES_FWD_EN
    // FIPS-197 forward S-box
    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        case (b)
            8'h00: fwd_sbox = 8'h63; 8'h01: fwd_sbox = 8'h7c; 8'h02: fwd_sbox = 8'h77; 8'h03: fwd_sbox = 8'h7b; 8'h04: fwd_sbox = 8'hf2; 8'h05: fwd_sbox = 8'h6b; 8'h06: fwd_sbox = 8'h6f; 8'h07: fwd_sbox = 8'hc5;
            8'h08: fwd_sbox = 8'h30; 8'h09: fwd_sbox = 8'h01; 8'h0a: fwd_sbox = 8'h67; 8'h0b: fwd_sbox = 8'h2b; 8'h0c: fwd_sbox = 8'hfe; 8'h0d: fwd_sbox = 8'hd7; 8'h0e: fwd_sbox = 8'hab; 8'h0f: fwd_sbox = 8'h76;
            8'h10: fwd_sbox = 8'hca; 8'h11: fwd_sbox = 8'h82; 8'h12: fwd_sbox = 8'hc9; 8'h13: fwd_sbox = 8'h7d; 8'h14: fwd_sbox = 8'hfa; 8'h15: fwd_sbox = 8'h59; 8'h16: fwd_sbox = 8'h47; 8'h17: fwd_sbox = 8'hf0;
            8'h18: fwd_sbox = 8'had; 8'h19: fwd_sbox = 8'hd4; 8'h1a: fwd_sbox = 8'ha2; 8'h1b: fwd_sbox = 8'haf; 8'h1c: fwd_sbox = 8'h9c; 8'h1d: fwd_sbox = 8'ha4; 8'h1e: fwd_sbox = 8'h72; 8'h1f: fwd_sbox = 8'hc0;
            8'h20: fwd_sbox = 8'hb7; 8'h21: fwd_sbox = 8'hfd; 8'h22: fwd_sbox = 8'h93; 8'h23: fwd_sbox = 8'h26; 8'h24: fwd_sbox = 8'h36; 8'h25: fwd_sbox = 8'h3f; 8'h26: fwd_sbox = 8'hf7; 8'h27: fwd_sbox = 8'hcc;
            8'h28: fwd_sbox = 8'h34; 8'h29: fwd_sbox = 8'ha5; 8'h2a: fwd_sbox = 8'he5; 8'h2b: fwd_sbox = 8'hf1; 8'h2c: fwd_sbox = 8'h71; 8'h2d: fwd_sbox = 8'hd8; 8'h2e: fwd_sbox = 8'h31; 8'h2f: fwd_sbox = 8'h15;
            8'h30: fwd_sbox = 8'h04; 8'h31: fwd_sbox = 8'hc7; 8'h32: fwd_sbox = 8'h23; 8'h33: fwd_sbox = 8'hc3; 8'h34: fwd_sbox = 8'h18; 8'h35: fwd_sbox = 8'h96; 8'h36: fwd_sbox = 8'h05; 8'h37: fwd_sbox = 8'h9a;
            8'h38: fwd_sbox = 8'h07; 8'h39: fwd_sbox = 8'h12; 8'h3a: fwd_sbox = 8'h80; 8'h3b: fwd_sbox = 8'he2; 8'h3c: fwd_sbox = 8'heb; 8'h3d: fwd_sbox = 8'h27; 8'h3e: fwd_sbox = 8'hb2; 8'h3f: fwd_sbox = 8'h75;
            8'h40: fwd_sbox = 8'h09; 8'h41: fwd_sbox = 8'h83; 8'h42: fwd_sbox = 8'h2c; 8'h43: fwd_sbox = 8'h1a; 8'h44: fwd_sbox = 8'h1b; 8'h45: fwd_sbox = 8'h6e; 8'h46: fwd_sbox = 8'h5a; 8'h47: fwd_sbox = 8'ha0;
            8'h48: fwd_sbox = 8'h52; 8'h49: fwd_sbox = 8'h3b; 8'h4a: fwd_sbox = 8'hd6; 8'h4b: fwd_sbox = 8'hb3; 8'h4c: fwd_sbox = 8'h29; 8'h4d: fwd_sbox = 8'he3; 8'h4e: fwd_sbox = 8'h2f; 8'h4f: fwd_sbox = 8'h84;
            8'h50: fwd_sbox = 8'h53; 8'h51: fwd_sbox = 8'hd1; 8'h52: fwd_sbox = 8'h00; 8'h53: fwd_sbox = 8'hed; 8'h54: fwd_sbox = 8'h20; 8'h55: fwd_sbox = 8'hfc; 8'h56: fwd_sbox = 8'hb1; 8'h57: fwd_sbox = 8'h5b;
            8'h58: fwd_sbox = 8'h6a; 8'h59: fwd_sbox = 8'hcb; 8'h5a: fwd_sbox = 8'hbe; 8'h5b: fwd_sbox = 8'h39; 8'h5c: fwd_sbox = 8'h4a; 8'h5d: fwd_sbox = 8'h4c; 8'h5e: fwd_sbox = 8'h58; 8'h5f: fwd_sbox = 8'hcf;
            8'h60: fwd_sbox = 8'hd0; 8'h61: fwd_sbox = 8'hef; 8'h62: fwd_sbox = 8'haa; 8'h63: fwd_sbox = 8'hfb; 8'h64: fwd_sbox = 8'h43; 8'h65: fwd_sbox = 8'h4d; 8'h66: fwd_sbox = 8'h33; 8'h67: fwd_sbox = 8'h85;
            8'h68: fwd_sbox = 8'h45; 8'h69: fwd_sbox = 8'hf9; 8'h6a: fwd_sbox = 8'h02; 8'h6b: fwd_sbox = 8'h7f; 8'h6c: fwd_sbox = 8'h50; 8'h6d: fwd_sbox = 8'h3c; 8'h6e: fwd_sbox = 8'h9f; 8'h6f: fwd_sbox = 8'ha8;
            8'h70: fwd_sbox = 8'h51; 8'h71: fwd_sbox = 8'ha3; 8'h72: fwd_sbox = 8'h40; 8'h73: fwd_sbox = 8'h8f; 8'h74: fwd_sbox = 8'h92; 8'h75: fwd_sbox = 8'h9d; 8'h76: fwd_sbox = 8'h38; 8'h77: fwd_sbox = 8'hf5;
            8'h78: fwd_sbox = 8'hbc; 8'h79: fwd_sbox = 8'hb6; 8'h7a: fwd_sbox = 8'hda; 8'h7b: fwd_sbox = 8'h21; 8'h7c: fwd_sbox = 8'h10; 8'h7d: fwd_sbox = 8'hff; 8'h7e: fwd_sbox = 8'hf3; 8'h7f: fwd_sbox = 8'hd2;
            8'h80: fwd_sbox = 8'hcd; 8'h81: fwd_sbox = 8'h0c; 8'h82: fwd_sbox = 8'h13; 8'h83: fwd_sbox = 8'hec; 8'h84: fwd_sbox = 8'h5f; 8'h85: fwd_sbox = 8'h97; 8'h86: fwd_sbox = 8'h44; 8'h87: fwd_sbox = 8'h17;
            8'h88: fwd_sbox = 8'hc4; 8'h89: fwd_sbox = 8'ha7; 8'h8a: fwd_sbox = 8'h7e; 8'h8b: fwd_sbox = 8'h3d; 8'h8c: fwd_sbox = 8'h64; 8'h8d: fwd_sbox = 8'h5d; 8'h8e: fwd_sbox = 8'h19; 8'h8f: fwd_sbox = 8'h73;
            8'h90: fwd_sbox = 8'h60; 8'h91: fwd_sbox = 8'h81; 8'h92: fwd_sbox = 8'h4f; 8'h93: fwd_sbox = 8'hdc; 8'h94: fwd_sbox = 8'h22; 8'h95: fwd_sbox = 8'h2a; 8'h96: fwd_sbox = 8'h90; 8'h97: fwd_sbox = 8'h88;
            8'h98: fwd_sbox = 8'h46; 8'h99: fwd_sbox = 8'hee; 8'h9a: fwd_sbox = 8'hb8; 8'h9b: fwd_sbox = 8'h14; 8'h9c: fwd_sbox = 8'hde; 8'h9d: fwd_sbox = 8'h5e; 8'h9e: fwd_sbox = 8'h0b; 8'h9f: fwd_sbox = 8'hdb;
            8'ha0: fwd_sbox = 8'he0; 8'ha1: fwd_sbox = 8'h32; 8'ha2: fwd_sbox = 8'h3a; 8'ha3: fwd_sbox = 8'h0a; 8'ha4: fwd_sbox = 8'h49; 8'ha5: fwd_sbox = 8'h06; 8'ha6: fwd_sbox = 8'h24; 8'ha7: fwd_sbox = 8'h5c;
            8'ha8: fwd_sbox = 8'hc2; 8'ha9: fwd_sbox = 8'hd3; 8'haa: fwd_sbox = 8'hac; 8'hab: fwd_sbox = 8'h62; 8'hac: fwd_sbox = 8'h91; 8'had: fwd_sbox = 8'h95; 8'hae: fwd_sbox = 8'he4; 8'haf: fwd_sbox = 8'h79;
            8'hb0: fwd_sbox = 8'he7; 8'hb1: fwd_sbox = 8'hc8; 8'hb2: fwd_sbox = 8'h37; 8'hb3: fwd_sbox = 8'h6d; 8'hb4: fwd_sbox = 8'h8d; 8'hb5: fwd_sbox = 8'hd5; 8'hb6: fwd_sbox = 8'h4e; 8'hb7: fwd_sbox = 8'ha9;
            8'hb8: fwd_sbox = 8'h6c; 8'hb9: fwd_sbox = 8'h56; 8'hba: fwd_sbox = 8'hf4; 8'hbb: fwd_sbox = 8'hea; 8'hbc: fwd_sbox = 8'h65; 8'hbd: fwd_sbox = 8'h7a; 8'hbe: fwd_sbox = 8'hae; 8'hbf: fwd_sbox = 8'h08;
            8'hc0: fwd_sbox = 8'hba; 8'hc1: fwd_sbox = 8'h78; 8'hc2: fwd_sbox = 8'h25; 8'hc3: fwd_sbox = 8'h2e; 8'hc4: fwd_sbox = 8'h1c; 8'hc5: fwd_sbox = 8'ha6; 8'hc6: fwd_sbox = 8'hb4; 8'hc7: fwd_sbox = 8'hc6;
            8'hc8: fwd_sbox = 8'he8; 8'hc9: fwd_sbox = 8'hdd; 8'hca: fwd_sbox = 8'h74; 8'hcb: fwd_sbox = 8'h1f; 8'hcc: fwd_sbox = 8'h4b; 8'hcd: fwd_sbox = 8'hbd; 8'hce: fwd_sbox = 8'h8b; 8'hcf: fwd_sbox = 8'h8a;
            8'hd0: fwd_sbox = 8'h70; 8'hd1: fwd_sbox = 8'h3e; 8'hd2: fwd_sbox = 8'hb5; 8'hd3: fwd_sbox = 8'h66; 8'hd4: fwd_sbox = 8'h48; 8'hd5: fwd_sbox = 8'h03; 8'hd6: fwd_sbox = 8'hf6; 8'hd7: fwd_sbox = 8'h0e;
            8'hd8: fwd_sbox = 8'h61; 8'hd9: fwd_sbox = 8'h35; 8'hda: fwd_sbox = 8'h57; 8'hdb: fwd_sbox = 8'hb9; 8'hdc: fwd_sbox = 8'h86; 8'hdd: fwd_sbox = 8'hc1; 8'hde: fwd_sbox = 8'h1d; 8'hdf: fwd_sbox = 8'h9e;
            8'he0: fwd_sbox = 8'he1; 8'he1: fwd_sbox = 8'hf8; 8'he2: fwd_sbox = 8'h98; 8'he3: fwd_sbox = 8'h11; 8'he4: fwd_sbox = 8'h69; 8'he5: fwd_sbox = 8'hd9; 8'he6: fwd_sbox = 8'h8e; 8'he7: fwd_sbox = 8'h94;
            8'he8: fwd_sbox = 8'h9b; 8'he9: fwd_sbox = 8'h1e; 8'hea: fwd_sbox = 8'h87; 8'heb: fwd_sbox = 8'he9; 8'hec: fwd_sbox = 8'hce; 8'hed: fwd_sbox = 8'h55; 8'hee: fwd_sbox = 8'h28; 8'hef: fwd_sbox = 8'hdf;
            8'hf0: fwd_sbox = 8'h8c; 8'hf1: fwd_sbox = 8'ha1; 8'hf2: fwd_sbox = 8'h89; 8'hf3: fwd_sbox = 8'h0d; 8'hf4: fwd_sbox = 8'hbf; 8'hf5: fwd_sbox = 8'he6; 8'hf6: fwd_sbox = 8'h42; 8'hf7: fwd_sbox = 8'h68;
            8'hf8: fwd_sbox = 8'h41; 8'hf9: fwd_sbox = 8'h99; 8'hfa: fwd_sbox = 8'h2d; 8'hfb: fwd_sbox = 8'h0f; 8'hfc: fwd_sbox = 8'hb0; 8'hfd: fwd_sbox = 8'h54; 8'hfe: fwd_sbox = 8'hbb; 8'hff: fwd_sbox = 8'h16;
        endcase
    endfunction
`endif

    // Lane inputs: pick the LANES bytes of the group currently being worked on
    always_comb begin
        w_lane_in = '0;
        for (int g = 0; g < c_NGRP; g++) begin
            if (r_grp == c_GW'(g)) begin
                for (int l = 0; l < LANES; l++) begin
                    w_lane_in[l] = r_data[127 - 8*(g*LANES + l) -: 8];
                end
            end
        end
    end

    // One S-box (or a forward/inverse pair) per lane
    for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef INV_SUBBYTES_FWD_EN
        assign w_lane_out[l] = r_fwd ? fwd_sbox(w_lane_in[l]) : inv_sbox(w_lane_in[l]);
`else
        assign w_lane_out[l] = inv_sbox(w_lane_in[l]);
`endif
    end

    // Merge substituted lane bytes back into their slots of the state
    always_comb begin
        w_data_sub = r_data;
        for (int g = 0; g < c_NGRP; g++) begin
            if (r_grp == c_GW'(g)) begin
                for (int l = 0; l < LANES; l++) begin
                    w_data_sub[127 - 8*(g*LANES + l) -: 8] = w_lane_out[l];
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_step = 1'b1;
                if (r_grp == c_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, group counter and mode latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_grp  <= '0;
`ifdef INV_SUBBYTES_FWD_EN
            r_fwd  <= 1'b0;
`endif
        end else if (w_load) begin
            r_data <= in;
            r_grp  <= '0;
`ifdef INV_SUBBYTES_FWD_EN
            r_fwd  <= fwd;
`endif
        end else if (w_step) begin
            r_data <= w_data_sub;
            r_grp  <= r_grp + c_GW'(1);
        end
    end

    assign out = r_data;

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_sub_bytes_seq
//  Description : Self-checking bench for inv_sub_bytes_seq. Main instance uses
//                LANES=4; four more instances cover LANES=1,2,8,16. Reference
//                S-boxes are derived from GF(2^8) arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] din;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;
`ifdef INV_SUBBYTES_FWD_EN
    logic         fwd;
`endif

    logic         sw_in_valid;
    logic [127:0] sw_in;
    logic [3:0]   sw_in_ready;
    logic [3:0]   sw_out_valid;
    logic [127:0] sw_out [4];
    logic         sw_out_ready;

    int n_checks;
    int n_pass;

    logic [7:0] ref_inv [256];
    logic [7:0] ref_fwd [256];

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout)
`ifdef INV_SUBBYTES_FWD_EN
        ,
        .fwd       (fwd)
`endif
    );

    for (genvar k = 0; k < 4; k++) begin : g_sweep
        localparam int c_LN = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 16;
        inv_sub_bytes_seq #(.LANES(c_LN)) u_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sw_in_valid),
            .in_ready  (sw_in_ready[k]),
            .in        (sw_in),
            .out_valid (sw_out_valid[k]),
            .out_ready (sw_out_ready),
            .out       (sw_out[k])
`ifdef INV_SUBBYTES_FWD_EN
            ,
            .fwd       (1'b0)
`endif
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_model();
        logic [7:0] b;
        logic [7:0] r;
        logic [7:0] s;
        for (int v = 0; v < 256; v++) begin
            b = v[7:0];
            r = 8'h01;
            for (int e = 0; e < 254; e++) r = gmul(r, b);
            s = r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
            ref_fwd[v] = s;
            ref_inv[s] = b;
        end
    endtask

    function automatic logic [127:0] model_inv(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = ref_inv[x[8*i +: 8]];
        return y;
    endfunction

    function automatic logic [127:0] model_fwd(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = ref_fwd[x[8*i +: 8]];
        return y;
    endfunction

    // One full transaction on the LANES=4 instance with out_ready held high
    task automatic run_one(input string tag, input logic [127:0] x, input logic [127:0] exp);
        int cnt;
        out_ready = 1'b1;
        check({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1;
        din      = x;
        tick();
        in_valid = 1'b0;
        din      = ~x;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 128'(cnt), 128'd4);
        check({tag, "_data"}, dout, exp);
        tick();
        check({tag, "_ovalid_pulse"}, {127'd0, out_valid}, 128'd0);
        check({tag, "_ready_back"}, {127'd0, in_ready}, 128'd1);
    endtask

    initial begin
        logic [127:0] x;
        logic [127:0] y;
        logic [127:0] held;
        int           lat [4];
        int           seen;

        n_checks     = 0;
        n_pass       = 0;
        in_valid     = 1'b0;
        din          = '0;
        out_ready    = 1'b1;
        sw_in_valid  = 1'b0;
        sw_in        = '0;
        sw_out_ready = 1'b1;
`ifdef INV_SUBBYTES_FWD_EN
        fwd          = 1'b0;
`endif
        build_model();

        // reset state
        repeat (3) tick();
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out", dout, 128'd0);
        rst_n = 1'b1;
        tick();

        // directed vectors
        run_one("v63", {16{8'h63}}, 128'h0);
        run_one("v00", {16{8'h00}}, {16{8'h52}});
        run_one("vff", {16{8'hff}}, {16{8'h7d}});
        run_one("vpat", {4{32'hd4ed167c}}, {4{32'h1953ff01}});
        x = 128'h000102030405060708090a0b0c0d0e0f;
        run_one("vramp", x, model_inv(x));

        // backpressure: hold DONE, second state must wait
        x = 128'h63cab7040953d051cd60e0e7ba70e18c;
        y = 128'h0123456789abcdeffedcba9876543210;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din       = x;
        tick();
        din  = y;
        seen = 0;
        while (!out_valid && seen < 40) begin
            tick();
            seen++;
        end
        held = dout;
        check("bp_first", held, model_inv(x));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_ovalid", {127'd0, out_valid}, 128'd1);
            check("bp_stable", dout, model_inv(x));
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_idle", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 40) begin
            tick();
            seen++;
        end
        check("bp_second_lat", 128'(seen), 128'd4);
        check("bp_second", dout, model_inv(y));
        tick();

        // reset two cycles after accept
        in_valid = 1'b1;
        din      = {16{8'h00}};
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_ovalid", {127'd0, out_valid}, 128'd0);
        check("mrst_out", dout, 128'd0);
        check("mrst_in_ready", {127'd0, in_ready}, 128'd1);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mrst_no_output", 128'(seen), 128'd0);
        check("mrst_idle", {127'd0, in_ready}, 128'd1);

`ifdef INV_SUBBYTES_FWD_EN
        fwd = 1'b1;
        run_one("fwd00", {16{8'h00}}, {16{8'h63}});
        x = {$urandom, $urandom, $urandom, $urandom};
        run_one("fwdrnd", x, model_fwd(x));
        fwd = 1'b0;
        run_one("roundtrip", model_fwd(x), x);
`endif

        // LANES sweep with random states
        for (int t = 0; t < 200; t++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            check("sw_ready", {124'd0, sw_in_ready}, 128'hf);
            sw_in_valid = 1'b1;
            sw_in       = x;
            tick();
            sw_in_valid = 1'b0;
            for (int k = 0; k < 4; k++) lat[k] = 0;
            for (int c = 1; c <= 20; c++) begin
                tick();
                for (int k = 0; k < 4; k++) begin
                    if (sw_out_valid[k] && lat[k] == 0) begin
                        lat[k] = c;
                        check($sformatf("sw_data_L%0d", k), sw_out[k], model_inv(x));
                    end
                end
            end
            check("sw_lat_L1", 128'(lat[0]), 128'd16);
            check("sw_lat_L2", 128'(lat[1]), 128'd8);
            check("sw_lat_L8", 128'(lat[2]), 128'd2);
            check("sw_lat_L16", 128'(lat[3]), 128'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
